// File: rtl/clock_div_param_if.sv
// Control/status bundle for clock_div_param: per-channel enables, the
// divisor write port, the phase-align request and the divided outputs.
interface clock_div_param_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 4
);
  logic [NUM_CH-1:0] en;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic              sync;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;

  modport master (
    output en, div_wr, div_sel, div_val, sync,
    input  clk_div, tick, div_pending
  );

  modport slave (
    input  en, div_wr, div_sel, div_val, sync,
    output clk_div, tick, div_pending
  );
endinterface

// File: rtl/clock_div_param.sv
// Multi-channel programmable clock-enable divider.
// Each channel runs a counter against an active divisor D and produces a
// registered waveform that is high for floor(D/2) cycles of every D, plus a
// one-cycle tick on each rising edge. New divisors go to a shadow register
// and are only promoted at a period boundary, so a write never shortens or
// splits a period already in progress.
// Optional feature: define CLK_DIV_PHASE_ALIGN_EN to let the sync input
// realign every channel so they all wrap on the same cycle.
module clock_div_param #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 32,
  parameter int SEL_W       = 4
) (
  input logic              clk_in,
  input logic              rst,
  clock_div_param_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_D   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  logic              wr_ok;
  logic [CNT_W-1:0]  wr_val;

`ifndef CLK_DIV_PHASE_ALIGN_EN
  // Alignment is compiled out; the port stays so both builds share one interface.
  logic sync_unused;
  assign sync_unused = bus.sync;
`endif

  // Write decode: out-of-range channels are dropped, divisors below 2 clamp to 2.
  always_comb begin
    wr_ok  = bus.div_wr && (32'(bus.div_sel) < NUM_CH);
    wr_val = (bus.div_val < MIN_D) ? MIN_D : bus.div_val;
  end

  // Per-channel next state: count/wrap, shadow promotion at wrap, shadow write.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      shd_d[i]  = shd_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      pend_d[i] = pend_q[i];

`ifdef CLK_DIV_PHASE_ALIGN_EN
      // Park every channel one step before wrap so the next enabled cycle
      // starts a fresh period on all of them at once.
      if (bus.sync) begin
        cnt_d[i] = div_q[i] - ONE;
        clk_d[i] = 1'b0;
      end else
`endif
      if (bus.en[i]) begin
        if (cnt_q[i] == div_q[i] - ONE) begin
          cnt_d[i]  = '0;
          clk_d[i]  = 1'b1;
          tick_d[i] = 1'b1;
          if (pend_q[i]) begin
            div_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
          clk_d[i] = (cnt_q[i] + ONE) < (div_q[i] >> 1);
        end
      end

      // A write landing on the wrap cycle goes to the shadow after the wrap
      // consumed the old shadow, so it stays pending for the next period.
      if (wr_ok && (bus.div_sel == SEL_W'(i))) begin
        shd_d[i]  = wr_val;
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset restores the default divisor and discards pending writes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= DEF_D - ONE;
        div_q[i] <= DEF_D;
        shd_q[i] <= DEF_D;
      end
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        shd_q[i] <= shd_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign bus.clk_div     = clk_q;
  assign bus.tick        = tick_q;
  assign bus.div_pending = pend_q;

endmodule

// File: tb/tb_clock_div_param.sv
// Directed bench for clock_div_param: a per-cycle vector table with small
// divisors, plus hand-written sequences for default period, enable freeze,
// write/wrap collision, mid-period reset and the sync input.
module tb_clock_div_param;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  clock_div_param_if #(.NUM_CH(4), .CNT_W(16), .SEL_W(4)) bus_if ();

  clock_div_param #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(32), .SEL_W(4)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic        wr;
    logic [3:0]  sel;
    logic [15:0] val;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_pend;
  } vec_t;

  vec_t tbl [21];
  int   n_vec = 0;

  task automatic add(input logic [3:0] en, input logic wr, input logic [3:0] sel,
                     input logic [15:0] val, input logic [3:0] c,
                     input logic [3:0] t, input logic [3:0] p);
    tbl[n_vec] = '{en, wr, sel, val, c, t, p};
    n_vec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.en      = '0;
    bus_if.div_wr  = 1'b0;
    bus_if.div_sel = '0;
    bus_if.div_val = '0;
    bus_if.sync    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write(input logic [3:0] sel, input logic [15:0] val);
    bus_if.div_wr  = 1'b1;
    bus_if.div_sel = sel;
    bus_if.div_val = val;
  endtask

  // Steps until tick[ch] rises; n is the number of cycles taken (bound on expiry).
  task automatic wait_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_if.tick[ch] && n < bound);
  endtask

  initial begin
    int n;
    int bad;
    logic [3:0] ec, et;

    rst = 1'b1;
    idle_inputs();

    // Table: load small divisors while disabled, then run them together.
    add(4'b0000, 1, 4'd0, 16'd2, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 1, 4'd1, 16'd3, 4'b0000, 4'b0000, 4'b0011);
    add(4'b0000, 1, 4'd2, 16'd0, 4'b0000, 4'b0000, 4'b0111);
    add(4'b0000, 1, 4'd7, 16'd9, 4'b0000, 4'b0000, 4'b0111);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1111, 4'b1111, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1101, 4'b0101, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1010, 4'b0010, 4'b0000);
    add(4'b1011, 0, 4'd0, 16'd0, 4'b1001, 4'b0001, 4'b0000);
    add(4'b1111, 1, 4'd0, 16'd5, 4'b1100, 4'b0100, 4'b0001);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1011, 4'b0011, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1101, 4'b0100, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1110, 4'b0110, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1101, 4'b0101, 4'b0000);
    add(4'b1111, 1, 4'd1, 16'd4, 4'b1011, 4'b0010, 4'b0010);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1100, 4'b0100, 4'b0010);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1000, 4'b0000, 4'b0010);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b1110, 4'b0110, 4'b0000);
    add(4'b1111, 0, 4'd0, 16'd0, 4'b0011, 4'b0001, 4'b0000);

    do_reset();
    chk("reset_clk_div", 32'(bus_if.clk_div), 32'h0);
    chk("reset_tick", 32'(bus_if.tick), 32'h0);
    chk("reset_pending", 32'(bus_if.div_pending), 32'h0);

    for (int v = 0; v < n_vec; v++) begin
      bus_if.en      = tbl[v].en;
      bus_if.div_wr  = tbl[v].wr;
      bus_if.div_sel = tbl[v].sel;
      bus_if.div_val = tbl[v].val;
      step();
      chk($sformatf("vec%0d_clk_div", v), 32'(bus_if.clk_div), 32'(tbl[v].exp_clk));
      chk($sformatf("vec%0d_tick", v), 32'(bus_if.tick), 32'(tbl[v].exp_tick));
      chk($sformatf("vec%0d_pending", v), 32'(bus_if.div_pending), 32'(tbl[v].exp_pend));
    end
    idle_inputs();

    // Default divisor: 16 high / 16 low, tick every 32, first tick one cycle after reset.
    do_reset();
    bus_if.en = 4'b1111;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      ec = (((k - 1) % 32) < 16) ? 4'hF : 4'h0;
      et = (((k - 1) % 32) == 0) ? 4'hF : 4'h0;
      if (k == 1) chk("first_tick", 32'(bus_if.tick), 32'hF);
      if (bus_if.clk_div !== ec || bus_if.tick !== et) bad++;
    end
    chk("default_wave_errors", 32'(bad), 32'h0);

    // Enable freeze on ch2 mid-high: output and counter hold, period stretches by 10.
    do_reset();
    bus_if.en = 4'b1111;
    repeat (5) step();
    bus_if.en = 4'b1011;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus_if.clk_div[2] !== 1'b1 || bus_if.tick[2] !== 1'b0) bad++;
    end
    chk("freeze_hold_errors", 32'(bad), 32'h0);
    bus_if.en = 4'b1111;
    wait_tick(2, 100, n);
    chk("freeze_resume_cycles", 32'(n), 32'd28);

    // Write on the wrap cycle of a channel with a pending shadow.
    do_reset();
    write(4'd0, 16'd2);
    step();
    write(4'd0, 16'd3);
    bus_if.en = 4'b0001;
    step();
    idle_inputs();
    bus_if.en = 4'b0001;
    chk("collide_tick", 32'(bus_if.tick[0]), 32'h1);
    chk("collide_still_pending", 32'(bus_if.div_pending[0]), 32'h1);
    step();
    chk("collide_old_applied_low", 32'(bus_if.clk_div[0]), 32'h0);
    step();
    chk("collide_d2_wrap", 32'(bus_if.tick[0]), 32'h1);
    chk("collide_pending_cleared", 32'(bus_if.div_pending[0]), 32'h0);
    wait_tick(0, 50, n);
    chk("collide_new_period", 32'(n), 32'd3);

    // Mid-period reset together with a write: reset wins, pending writes dropped.
    do_reset();
    bus_if.en = 4'b1111;
    write(4'd1, 16'd5);
    step();
    bus_if.div_wr = 1'b0;
    repeat (3) step();
    write(4'd3, 16'd7);
    rst = 1'b1;
    step();
    chk("midrst_clk_div", 32'(bus_if.clk_div), 32'h0);
    chk("midrst_tick", 32'(bus_if.tick), 32'h0);
    chk("midrst_pending", 32'(bus_if.div_pending), 32'h0);
    rst = 1'b0;
    bus_if.div_wr = 1'b0;
    step();
    chk("midrst_first_edge", 32'(bus_if.tick), 32'hF);
    wait_tick(1, 100, n);
    chk("midrst_period", 32'(n), 32'd32);

`ifdef CLK_DIV_PHASE_ALIGN_EN
    // D=8 and D=12 out of phase, sync pulse aligns their next wrap.
    do_reset();
    write(4'd0, 16'd8);
    step();
    write(4'd1, 16'd12);
    step();
    bus_if.div_wr = 1'b0;
    bus_if.en = 4'b0001;
    repeat (3) step();
    bus_if.en = 4'b0011;
    repeat (4) step();
    bus_if.sync = 1'b1;
    step();
    chk("sync_clk_div", 32'(bus_if.clk_div), 32'h0);
    chk("sync_tick", 32'(bus_if.tick), 32'h0);
    bus_if.sync = 1'b0;
    bus_if.en = 4'b1111;
    step();
    chk("sync_aligned_tick", 32'(bus_if.tick), 32'hF);
    wait_tick(0, 50, n);
    chk("sync_ch0_period", 32'(n), 32'd8);
`else
    // Without alignment support sync must have no effect.
    do_reset();
    bus_if.en = 4'b1111;
    repeat (5) step();
    bus_if.sync = 1'b1;
    step();
    chk("sync_ignored_clk_div", 32'(bus_if.clk_div), 32'hF);
    chk("sync_ignored_tick", 32'(bus_if.tick), 32'h0);
    bus_if.sync = 1'b0;
    wait_tick(0, 100, n);
    chk("sync_ignored_period", 32'(n), 32'd27);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_div_param.md
# clock_div_param

Parametrised multi-channel clock divider, the generalised successor to the fixed divide-by-32 block. Generates `NUM_CH` independent divided clock-enable waveforms from `clk_in`, each with a runtime-programmable divisor, near-50% duty cycle, per-channel enable and a one-cycle rising-edge tick. Divisor updates are shadowed and take effect only at a period boundary, so outputs never glitch. It feeds the display and sampling logic that previously used hard-wired dividers.

## Interface
- `NUM_CH`, 4, number of divider channels (1..16)
- `CNT_W`, 16, divisor and counter width in bits
- `DEFAULT_DIV`, 32, divisor loaded into every channel at reset (2..2^CNT_W-1)
- `SEL_W`, 4, width of `div_sel`
- `clk_in`  input  1  system clock; all logic on its rising edge
- `rst`  input  1  synchronous, active-high reset
- `en`  input  NUM_CH  per-channel count enable
- `div_wr`  input  1  divisor write strobe, one cycle
- `div_sel`  input  SEL_W  target channel of the write
- `div_val`  input  CNT_W  new divisor value
- `sync`  input  1  phase-align request (used only with `CLK_DIV_PHASE_ALIGN_EN`)
- `clk_div`  output  NUM_CH  divided waveforms, registered
- `tick`  output  NUM_CH  one-cycle pulse coincident with each `clk_div` rising edge
- `div_pending`  output  NUM_CH  shadow divisor waiting to be applied

## Operation
- Per channel: active divisor D, shadow divisor S, counter `cnt` (CNT_W bits), H = floor(D/2).
- Reset: D = S = DEFAULT_DIV, `cnt` = DEFAULT_DIV-1, `clk_div` = 0, `tick` = 0, `div_pending` = 0.
- Enabled cycle (`en[i]`=1): if `cnt` == D-1 → `cnt` ← 0, `clk_div` ← 1, `tick` ← 1 (wrap); else `cnt` ← `cnt`+1, `clk_div` ← (`cnt`+1 < H), `tick` ← 0.
- Result: period D cycles, high H cycles, low D-H cycles; D=32 → 16/16; D=5 → 2 high/3 low.
- Disabled cycle: `cnt`, `clk_div` hold; `tick` ← 0.
- Write: `div_wr`=1 with `div_sel` < NUM_CH → S[sel] ← max(`div_val`, 2), `div_pending[sel]` ← 1. `div_sel` ≥ NUM_CH: write ignored.
- Apply: on a wrap with `div_pending[i]`=1 → D ← S, `div_pending[i]` ← 0; the period beginning at that wrap uses the new D (H recomputed from it).
- Write and wrap in the same cycle on the same channel: wrap applies the pre-write S; new value lands in S and `div_pending` stays 1 for the next wrap.
- Channels fully independent; no shared state besides the write port.

## Timing
- First rising edge: one cycle after `rst` falls with `en[i]`=1 (`clk_div`=1, `tick`=1 at that edge).
- Write-to-apply latency: up to D cycles (next wrap of that channel); 0 extra cycles once the wrap occurs.
- All outputs registered; no combinational path from inputs to outputs.
- `rst` mid-period: next edge returns all channels to reset state, discarding pending writes.
- `rst` and `div_wr` in the same cycle: reset wins; write lost.

## Configuration
- `CLK_DIV_PHASE_ALIGN_EN` defined: `sync`=1 for one cycle forces every channel `cnt` ← D-1, `clk_div` ← 0, `tick` ← 0 (pending divisors kept); the next enabled cycle wraps all channels together, applying pending divisors. `sync` outranks normal counting, loses to `rst`.
- Not defined: `sync` port present but ignored; no alignment logic synthesised.

## Test plan
- Reset, `en`=all 1, default params → each `clk_div` 16 high/16 low, `tick` pulses every 32 cycles, first at cycle 1 after reset.
- Write ch1 `div_val`=5 mid-period → `div_pending[1]`=1 until ch1 wrap, then period 5 (2 high/3 low); other channels unchanged at 32.
- Write `div_val`=0 and `div_val`=1 → behaves as D=2 (1 high/1 low); write with `div_sel`=7 (NUM_CH=4) → no state change.
- Drop `en[2]` for 10 cycles mid-high → `clk_div[2]` and counter frozen, no `tick`; resumes with period stretched by exactly 10.
- Write coinciding with wrap → old S applied, new value applied one period later; assert `rst` mid-period → all outputs to reset values next edge.
- With `CLK_DIV_PHASE_ALIGN_EN`, channels at D=8 and D=12 out of phase, pulse `sync` → both `tick` asserted on the same cycle one cycle later.
